// File: rtl/fifo_sched_pkg.sv
// ---------------------------------------------------------------------------
// fifo_sched_pkg
// Shared constants and types for the channel FIFO round-robin read scheduler.
//   NUM_CH  : number of channel FIFOs behind the 8:1 mux
//   CH_W    : width of a channel index / mux select
//   DATA_W  : channel FIFO word width
//   state_e : scheduler FSM states
// ---------------------------------------------------------------------------
package fifo_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 128;

    // IDLE  : arbitrate among non-empty channels
    // GRANT : one settle cycle after the mux select changes
    // READ  : pop up to BURST_LEN words from the granted channel
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb8.sv
// ---------------------------------------------------------------------------
// rr_arb8
// Purely combinational 8-way round-robin arbiter.
// The request vector is rotated so the channel after last_grant_i sits at
// bit 0, then the lowest set bit is picked and mapped back to a channel index.
// Ports:
//   req_i        : per-channel request (1 = channel has data)
//   last_grant_i : channel granted most recently (lowest priority next)
//   grant_o      : winning channel (valid only when any_req_o = 1)
//   any_req_o    : at least one request is present
// ---------------------------------------------------------------------------
module rr_arb8
    import fifo_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_grant_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              any_req_o
);

    logic [CH_W-1:0]     start;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W-1:0]     offset;

    // Search begins one past the last winner; the 3-bit add wraps modulo 8.
    assign start   = last_grant_i + 3'd1;
    assign req_dbl = {req_i, req_i};
    // req_rot[k] corresponds to channel (start + k) mod 8.
    assign req_rot = req_dbl[start +: NUM_CH];

    // Lowest set bit of the rotated vector wins (scan high to low, last hit).
    always_comb begin
        offset = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = CH_W'(k);
            end
        end
    end

    assign grant_o   = start + offset;
    assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_rr_scheduler
// Round-robin read scheduler for the channel FIFO bank behind the 8:1 mux.
// In IDLE it picks the next non-empty channel, drives the mux select, waits
// one settle cycle, then pops up to BURST_LEN words (FWFT FIFOs) and forwards
// them through a single registered valid/ready output stage.
//
// Output handshake: a word transfers on every rising edge where
// out_valid & out_ready are both 1. While out_valid=1 and out_ready=0 the
// word (out_data/out_chan/out_last) is held unchanged and nothing is popped.
// A new pop may replace the register in the same cycle the consumer takes the
// current word, giving one word per clock when the consumer never stalls.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : permits new grants (only looked at in IDLE)
//   empty_vec  : per-channel FIFO empty flags
//   address    : registered mux select
//   rd_en      : combinational pop to the selected FIFO
//   empty/dout : selected-channel empty flag and FWFT data from the mux
//   out_valid/out_ready/out_data/out_chan/out_last : downstream word stream
//   busy       : scheduler is not in IDLE
// ---------------------------------------------------------------------------
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int DATA_W    = fifo_sched_pkg::DATA_W,
    parameter int NUM_CH    = fifo_sched_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] empty_vec,
    output logic [CH_W-1:0]   address,
    output logic              rd_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_chan,
    output logic              out_last,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     address_q, address_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_chan_q, out_chan_d;
    logic                out_last_q, out_last_d;

    logic [CH_W-1:0]     arb_grant;
    logic                arb_any;
    logic                last_word;

    rr_arb8 u_arb (
        .req_i        (~empty_vec),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    // cnt only ever counts up to BURST_LEN-1 within a grant, so it cannot wrap.
    assign last_word = (cnt_q == 8'(BURST_LEN - 1));

    // Pop only from a non-empty FIFO, and only when the output register is
    // free or being emptied by the consumer this cycle.
    assign rd_en = (state_q == READ) & ~empty & (~out_valid_q | out_ready);

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_last_d   = out_last_q;

        case (state_q)
            IDLE: begin
                if (enable && arb_any) begin
                    address_d    = arb_grant;
                    last_grant_d = arb_grant;
                    cnt_d        = '0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                state_d = READ;
            end
            READ: begin
                if (rd_en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end else if (empty) begin
                    // Channel ran dry before the burst limit: end the grant.
                    state_d = IDLE;
                end
                // Otherwise the output is stalled: hold.
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = dout;
            out_chan_d  = address_q;
            out_last_d  = last_word;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_last_q   <= out_last_d;
        end
    end

    assign address   = address_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_scheduler
// Bench for fifo_rr_scheduler. The channel FIFOs and mux are modelled with
// queues. A transaction-level model predicts the whole output stream from the
// channel contents (round-robin over non-empty channels, up to BL words per
// grant, last flag on the BL-th word) and pushes it into exp_q; a monitor
// pops and compares on every accepted output word.
// ---------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

    localparam int DW = 128;
    localparam int BL = 8;
    localparam int W  = DW + 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [7:0]    empty_vec;
    logic [2:0]    address;
    logic          rd_en;
    logic          empty;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_chan;
    logic          out_last;
    logic          busy;

    logic [DW-1:0] env_q [8][$];
    logic [DW-1:0] mdl_q [8][$];
    logic [W-1:0]  exp_q [$];
    int            mdl_last;

    int            checks;
    int            failures;
    int            ready_mode;
    int            pat_idx;
    logic [3:0]    ready_pat;
    int            rd_cnt;
    logic          stall_prev;
    logic [W-1:0]  held;

    fifo_rr_scheduler #(
        .BURST_LEN (BL),
        .DATA_W    (DW),
        .NUM_CH    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .empty_vec (empty_vec),
        .address   (address),
        .rd_en     (rd_en),
        .empty     (empty),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < 8; i++) begin
            empty_vec[i] = (env_q[i].size() == 0);
        end
        empty = (env_q[address].size() == 0);
        dout  = empty ? '0 : env_q[address][0];
    endfunction

    task automatic load(input int ch, input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            env_q[ch].push_back(d);
            mdl_q[ch].push_back(d);
        end
        refresh();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 8; i++) begin
            env_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        mdl_last = 7;
        refresh();
    endtask

    // Reference model: grant order and burst shapes from the channel contents.
    task automatic model_grants(input int n);
        int found;
        int c;
        int k;
        for (int g = 0; g < n; g++) begin
            found = -1;
            for (int i = 1; i <= 8; i++) begin
                c = (mdl_last + i) % 8;
                if (found < 0 && mdl_q[c].size() > 0) found = c;
            end
            if (found < 0) return;
            mdl_last = found;
            k = (mdl_q[found].size() < BL) ? mdl_q[found].size() : BL;
            for (int j = 0; j < k; j++) begin
                exp_q.push_back({(j == BL - 1), 3'(found), mdl_q[found].pop_front()});
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (n < budget && (exp_q.size() != 0 || busy || out_valid)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout pending=%0d busy=%0b out_valid=%0b", name, exp_q.size(), busy, out_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_address"},   address,   0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_chan"},  out_chan,  0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_rd_en"},     rd_en,     0);
    endtask

    // ---------------- FIFO bank / mux environment ----------------
    always @(posedge clk) begin
        if (rst_n && rd_en) begin
            if (env_q[address].size() > 0) void'(env_q[address].pop_front());
            rd_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = ready_pat[pat_idx];
                pat_idx   = (pat_idx + 1) % 4;
            end
        endcase
        refresh();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("no_underflow_pop", rd_en & empty, 0);
            if (stall_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_word", {out_last, out_chan, out_data}, held);
            end
            if (out_valid && !out_ready) chk("stall_no_rd_en", rd_en, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h expected=none", {out_last, out_chan, out_data});
                end else begin
                    chk("out_word", {out_last, out_chan, out_data}, exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_chan, out_data};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int viol;
        checks     = 0;
        failures   = 0;
        ready_mode = 0;
        pat_idx    = 0;
        ready_pat  = 4'b1001;   // bit0 first: 1,0,0,1
        rd_cnt     = 0;
        stall_prev = 1'b0;
        held       = '0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        out_ready  = 1'b1;
        clear_all();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Channel 3 with two words: grant, settle, two pops, no last flag.
        load(3, 2);
        model_grants(100);
        rd_cnt = 0;
        enable = 1'b1;
        @(negedge clk);
        chk("t1_busy_after_grant", busy, 1);
        chk("t1_address", address, 3);
        chk("t1_no_pop_in_settle", rd_en, 0);
        @(negedge clk);
        chk("t1_first_pop", rd_en, 1);
        wait_drain(100, "t1_drain");
        chk("t1_pop_count", rd_cnt, 2);
        enable = 1'b0;

        // Three channels of 20 words: round robin 0,1,2 with 8,8,4 bursts.
        load(0, 20);
        load(1, 20);
        load(2, 20);
        model_grants(100);
        enable = 1'b1;
        wait_drain(2000, "t2_drain");
        enable = 1'b0;

        // Channel 5 under a 1,0,0,1 ready pattern.
        load(5, 20);
        model_grants(100);
        pat_idx    = 0;
        ready_mode = 2;
        enable     = 1'b1;
        wait_drain(2000, "t3_drain");
        enable     = 1'b0;
        ready_mode = 0;

        // All channels empty with enable high: nothing may happen.
        enable = 1'b1;
        viol   = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en || out_valid || busy) viol++;
        end
        chk("t4_idle_when_all_empty", viol, 0);
        enable = 1'b0;

        // Asynchronous reset in the middle of a channel 6 burst.
        load(6, 20);
        model_grants(1);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        enable = 1'b0;
        clear_all();
        load(0, 3);
        load(6, 4);
        model_grants(100);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("t5_first_grant_ch0", address, 0);
        chk("t5_busy", busy, 1);
        wait_drain(500, "t5_drain");
        enable = 1'b0;

        // Enable dropped during channel 0 burst.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) load(c, $urandom_range(9, 20));
        model_grants(1);
        ready_mode = 1;
        enable     = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("t6_granted_ch0", address, 0);
        wait_drain(500, "t6_first_burst");
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || out_valid || rd_en) viol++;
        end
        chk("t6_no_grant_while_disabled", viol, 0);
        model_grants(1000);
        enable = 1'b1;
        wait_drain(5000, "t6_rest");
        enable = 1'b0;

        // Random rounds.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 3) != 0) load(c, $urandom_range(1, 20));
            end
            model_grants(1000);
            ready_mode = $urandom_range(0, 1);
            enable     = 1'b1;
            wait_drain(5000, "rand_drain");
            enable = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Round-robin read scheduler for the eight 128-bit channel FIFOs behind the 8:1 channel mux.
- Picks the next non-empty channel and drives the mux select (address) and shared rd_en.
- Pops up to BURST_LEN words per grant and forwards them to the downstream consumer through a registered valid/ready output stage.
- Sits between the channel FIFO bank/mux and the downstream write path.

Parameters:
BURST_LEN, 8, maximum words popped per grant (1..255)
DATA_W, 128, FIFO word width
NUM_CH, 8, number of channels (fixed at 8; select is 3 bits)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits new grants; sampled only in IDLE
empty_vec  input  8  per-channel FIFO empty flags, bit i = channel i
address  output  3  channel select to mux, registered
rd_en  output  1  pop to selected FIFO via mux, combinational
empty  input  1  selected-channel empty from mux
dout  input  DATA_W  selected-channel data from mux; FWFT, valid when empty=0
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts word when out_valid&out_ready
out_data  output  DATA_W  forwarded word
out_chan  output  3  source channel of out_data
out_last  output  1  marks BURST_LEN-th word of a grant
busy  output  1  high when state != IDLE

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE; address=0; out_valid=0; out_data=0; out_chan=0; out_last=0; cnt=0; rr pointer last_grant=7, so channel 0 has first priority. rd_en is 0 while in reset.
- FIFOs are first-word-fall-through: dout is valid whenever empty=0, and rd_en pops that word at the clock edge.
- State IDLE:
  - If enable=1 and empty_vec!=8'hFF, grant the first channel with empty_vec bit 0, searching last_grant+1, +2, …, modulo 8.
  - On grant: address<=grant, last_grant<=grant, cnt<=0, go GRANT.
  - Otherwise stay in IDLE.
- State GRANT: one settle cycle so that address and the mux outputs are stable. rd_en=0. Go READ.
- State READ, pop condition:
  - rd_en = (state==READ) & ~empty & (~out_valid | out_ready).
  - On a pop: out_data<=dout, out_chan<=address, out_valid<=1, out_last<=(cnt==BURST_LEN-1), cnt<=cnt+1.
  - If cnt==BURST_LEN-1 at the pop, go IDLE.
- State READ, other cases:
  - If empty=1 in READ with no pop, the burst ends early: go IDLE. No out_last is produced for that burst.
  - If the output is stalled (out_valid=1, out_ready=0), there is no pop and the state is held.
- Output stage:
  - If out_valid & out_ready with no pop in the same cycle, out_valid<=0.
  - A pop while out_valid & out_ready overwrites the register. This gives back-to-back throughput of 1 word/clk.
  - out_data, out_chan and out_last hold while stalled.
- Latency: dout to out_data is 1 clk. Grant decision to first pop is 2 clk (IDLE→GRANT→READ).
- address changes only on the IDLE grant. It never changes while rd_en can be 1, so no mid-burst channel switch.
- enable deasserted mid-burst: the current burst completes normally. No new grant is made.
- A channel that becomes non-empty while another is bursting waits for the next IDLE arbitration.
- Fairness: a channel is granted at most once before every other requesting channel has had one grant.
- cnt is 8 bits. It is compared only against BURST_LEN-1, so it never wraps.
- rd_en is never asserted when empty=1, so no underflow pop is possible.

Decomposition:
- Shared package fifo_sched_pkg: NUM_CH=8, CH_W=3, DATA_W=128, state enum {IDLE, GRANT, READ}.
- One sub-module, rr_arb8: 8-bit request vector plus 3-bit last_grant in; 3-bit grant plus any_req out. Purely combinational, rotate then priority-encode.
- The FSM, counter and output register stay in fifo_rr_scheduler.

Test Plan:
- Reset then channel 3 holds 2 words (A,B), others empty, out_ready=1 → address=3; rd_en high 2 cycles; out_data A then B with out_chan=3; out_last=0; back to IDLE.
- Channels 0,1,2 each hold 20 words, BURST_LEN=8 → grant order 0,1,2,0,1,2,0,1,2; bursts of 8,8,4 words per channel; out_last on words 8 and 16 of each channel only.
- Channel 5 full, out_ready toggles 1,0,0,1 → no rd_en in the stalled cycles; out_data stable while stalled; no words lost or duplicated (sequence checked by scoreboard).
- All channels non-empty, enable dropped during channel 0 burst → channel 0 finishes 8 words; busy falls; no further grant until enable=1.
- rst_n asserted mid-burst on channel 6 → all outputs return to reset values asynchronously; after release, the first grant is channel 0 if non-empty.
- empty_vec=8'hFF with enable=1 for 100 clk → rd_en=0, out_valid=0, busy=0 throughout.
